// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode constants, default width,
// the buffered entry type and the skid-buffer occupancy states.
package alu_pkg;

   localparam int ALU_WIDTH = 4;

   localparam logic [2:0] ALU_SEL_ADD = 3'b000;
   localparam logic [2:0] ALU_SEL_SUB = 3'b001;
   localparam logic [2:0] ALU_SEL_AND = 3'b010;
   localparam logic [2:0] ALU_SEL_OR  = 3'b011;
   localparam logic [2:0] ALU_SEL_XOR = 3'b100;
   localparam logic [2:0] ALU_SEL_NOT = 3'b101;
   localparam logic [2:0] ALU_SEL_SHL = 3'b110;
   localparam logic [2:0] ALU_SEL_SHR = 3'b111;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      logic [2:0]           sel;
      logic                 c;
      logic                 z;
      logic                 n;
   } alu_entry_t;

   typedef enum logic [1:0] {
      SKID_EMPTY,
      SKID_ONE,
      SKID_FULL
   } skid_state_e;

   // Carry only means something for arithmetic opcodes.
   function automatic logic carry_qualified(input logic [2:0] sel, input logic carry);
      return ((sel == ALU_SEL_ADD) || (sel == ALU_SEL_SUB)) ? carry : 1'b0;
   endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer. MAIN drives the output; SKID holds the
// one extra entry so the producer is never stalled mid-transfer.
module alu_skid_buffer
   import alu_pkg::*;
#(
   parameter type    entry_t   = alu_entry_t,
   parameter entry_t RESET_VAL = '0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  entry_t in_data,
   output logic   out_valid,
   input  logic   out_ready,
   output entry_t out_data
);

   skid_state_e state_q, state_d;
   entry_t      main_q, main_d;
   entry_t      skid_q, skid_d;
   logic        in_xfer;
   logic        out_xfer;

   assign in_ready  = (state_q != SKID_FULL);
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = main_q;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      // NOTE: every output of this block gets its default first, so no path can infer a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         SKID_EMPTY: begin
            if (in_xfer) begin
               main_d  = in_data;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            unique case ({in_xfer, out_xfer})
               2'b10: begin
                  skid_d  = in_data;
                  state_d = SKID_FULL;
               end
               2'b01: state_d = SKID_EMPTY;
               2'b11: main_d  = in_data;
               default: ;
            endcase
         end
         SKID_FULL: begin
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   // NOTE: data registers are reset too, so the outputs show defined values straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SKID_EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: derives Z/N/C at capture, buffers through a
// 2-entry skid, and keeps a sticky carry plus a wrapping count of delivered results.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_result,
   input  logic               in_carry,
   input  logic [2:0]         in_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic [2:0]         out_sel,
   output logic               out_c,
   output logic               out_z,
   output logic               out_n,
   output logic               sticky_c,
   input  logic               clear_sticky,
   output logic [COUNT_W-1:0] result_count
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [2:0]       sel;
      logic             c;
      logic             z;
      logic             n;
   } entry_t;

   // An empty stage reports a zero result, hence z set at reset.
   localparam entry_t ENTRY_RESET = '{result: '0, sel: '0, c: 1'b0, z: 1'b1, n: 1'b0};

   entry_t             in_entry;
   entry_t             out_entry;
   logic               in_xfer;
   logic               out_xfer;
   logic               sticky_q, sticky_d;
   logic [COUNT_W-1:0] count_q, count_d;

   always_comb begin
      in_entry.result = in_result;
      in_entry.sel    = in_sel;
      in_entry.c      = carry_qualified(in_sel, in_carry);
      in_entry.z      = (in_result == '0);
      in_entry.n      = in_result[WIDTH-1];
   end

   alu_skid_buffer #(
      .entry_t   (entry_t),
      .RESET_VAL (ENTRY_RESET)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_entry)
   );

   assign out_result = out_entry.result;
   assign out_sel    = out_entry.sel;
   assign out_c      = out_entry.c;
   assign out_z      = out_entry.z;
   assign out_n      = out_entry.n;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_comb begin
      sticky_d = sticky_q;
      count_d  = count_q;
      // A carry-1 capture outranks a simultaneous clear.
      if (in_xfer && in_entry.c) begin
         sticky_d = 1'b1;
      end else if (clear_sticky) begin
         sticky_d = 1'b0;
      end
      if (out_xfer) begin
         count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign sticky_c     = sticky_q;
   assign result_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic
// scored against a queue-based transaction model of the stage.
module tb_alu_result_stage;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_result = '0;
   logic       in_carry = 1'b0;
   logic [2:0] in_sel = '0;
   logic       out_ready = 1'b0;
   logic       clear_sticky = 1'b0;

   logic       in_ready, out_valid, out_c, out_z, out_n, sticky_c;
   logic [3:0] out_result;
   logic [2:0] out_sel;
   logic [7:0] result_count;

   logic       w2_in_ready, w2_out_valid, w2_out_c, w2_out_z, w2_out_n, w2_sticky_c;
   logic [3:0] w2_out_result;
   logic [2:0] w2_out_sel;
   logic [1:0] w2_result_count;

   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(4), .COUNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_carry(in_carry), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_sel(out_sel), .out_c(out_c), .out_z(out_z), .out_n(out_n),
      .sticky_c(sticky_c), .clear_sticky(clear_sticky), .result_count(result_count)
   );

   alu_result_stage #(.WIDTH(4), .COUNT_W(2)) dut_w2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w2_in_ready),
      .in_result(in_result), .in_carry(in_carry), .in_sel(in_sel),
      .out_valid(w2_out_valid), .out_ready(out_ready), .out_result(w2_out_result),
      .out_sel(w2_out_sel), .out_c(w2_out_c), .out_z(w2_out_z), .out_n(w2_out_n),
      .sticky_c(w2_sticky_c), .clear_sticky(clear_sticky), .result_count(w2_result_count)
   );

   typedef struct {
      logic [3:0] result;
      logic [2:0] sel;
      logic       c;
      logic       z;
      logic       n;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_count = '0;
   logic       m_sticky = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   function automatic exp_t model(input logic [3:0] r, input logic [2:0] s, input logic cy);
      exp_t e;
      e.result = r;
      e.sel    = s;
      e.c      = (s == ALU_SEL_ADD || s == ALU_SEL_SUB) ? cy : 1'b0;
      e.z      = (r == 4'd0);
      e.n      = r[3];
      return e;
   endfunction

   // Transaction-level scoreboard, evaluated mid-cycle every cycle.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_count  = '0;
         m_sticky = 1'b0;
      end else begin
         logic exp_ov, exp_ir, acc_in;
         exp_t e;
         exp_ov = (q.size() > 0);
         exp_ir = (q.size() < 2);
         n_cmp++;
         if ({out_valid, in_ready} !== {exp_ov, exp_ir}) begin
            n_bad++;
            $display("FAIL sb_handshake: got valid/ready %b%b want %b%b", out_valid, in_ready, exp_ov, exp_ir);
         end
         n_cmp++;
         if ({w2_out_valid, w2_in_ready} !== {exp_ov, exp_ir}) begin
            n_bad++;
            $display("FAIL sb_w2_handshake: got %b%b want %b%b", w2_out_valid, w2_in_ready, exp_ov, exp_ir);
         end
         if (exp_ov) begin
            n_cmp++;
            if ({out_result, out_sel, out_c, out_z, out_n} !== {q[0].result, q[0].sel, q[0].c, q[0].z, q[0].n}) begin
               n_bad++;
               $display("FAIL sb_data: got r=%h s=%h c%b z%b n%b want r=%h s=%h c%b z%b n%b",
                        out_result, out_sel, out_c, out_z, out_n, q[0].result, q[0].sel, q[0].c, q[0].z, q[0].n);
            end
            n_cmp++;
            if ({w2_out_result, w2_out_sel, w2_out_c, w2_out_z, w2_out_n} !== {q[0].result, q[0].sel, q[0].c, q[0].z, q[0].n}) begin
               n_bad++;
               $display("FAIL sb_w2_data: got r=%h s=%h want r=%h s=%h", w2_out_result, w2_out_sel, q[0].result, q[0].sel);
            end
         end
         n_cmp++;
         if ({sticky_c, w2_sticky_c} !== {m_sticky, m_sticky}) begin
            n_bad++;
            $display("FAIL sb_sticky: got %b/%b want %b", sticky_c, w2_sticky_c, m_sticky);
         end
         n_cmp++;
         if (result_count !== m_count || w2_result_count !== m_count[1:0]) begin
            n_bad++;
            $display("FAIL sb_count: got %0d/%0d want %0d/%0d", result_count, w2_result_count, m_count, m_count[1:0]);
         end
         // Advance the model to the state after the coming rising edge.
         acc_in = in_valid && exp_ir;
         e = model(in_result, in_sel, in_carry);
         if (exp_ov && out_ready) begin
            void'(q.pop_front());
            m_count = m_count + 8'd1;
         end
         if (acc_in) q.push_back(e);
         if (acc_in && e.c) m_sticky = 1'b1;
         else if (clear_sticky) m_sticky = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] r, input logic cy, input logic [2:0] s);
      in_valid  = v;
      in_result = r;
      in_carry  = cy;
      in_sel    = s;
   endtask

   task automatic drain();
      drive(1'b0, 4'd0, 1'b0, 3'd0);
      out_ready    = 1'b1;
      clear_sticky = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      n_cmp++;
      if ({out_valid, in_ready, out_result, out_sel, out_c, out_z, out_n, sticky_c, result_count, w2_result_count}
          !== {1'b0, 1'b1, 4'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0}) begin
         n_bad++;
         $display("FAIL reset_values: got v%b r%b res=%h sel=%h c%b z%b n%b st%b cnt=%0d/%0d",
                  out_valid, in_ready, out_result, out_sel, out_c, out_z, out_n, sticky_c, result_count, w2_result_count);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL reset_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_add_carry();
      out_ready = 1'b1;
      drive(1'b1, 4'h0, 1'b1, ALU_SEL_ADD);
      step();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      n_cmp++;
      if ({out_valid, out_result, out_c, out_z, out_n, sticky_c} !== {1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL add_carry: got v%b res=%h c%b z%b n%b st%b want v1 res=0 c1 z1 n0 st1",
                  out_valid, out_result, out_c, out_z, out_n, sticky_c);
      end
      step();
      n_cmp++;
      if (result_count !== 8'd1) begin
         n_bad++;
         $display("FAIL add_count: got %0d want 1", result_count);
      end
   endtask

   task automatic test_and_flags();
      out_ready = 1'b1;
      drive(1'b1, 4'h8, 1'b1, ALU_SEL_AND);
      step();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      n_cmp++;
      if ({out_valid, out_result, out_c, out_z, out_n, sticky_c} !== {1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL and_flags: got v%b res=%h c%b z%b n%b st%b want v1 res=8 c0 z0 n1 st1",
                  out_valid, out_result, out_c, out_z, out_n, sticky_c);
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [3:0] vals[3];
      logic [3:0] got[$];
      logic       sent_c;
      vals[0] = 4'($urandom_range(0, 15));
      vals[1] = vals[0] + 4'd5;
      vals[2] = vals[0] + 4'd10;
      out_ready = 1'b0;
      drive(1'b1, vals[0], 1'b0, 3'($urandom_range(0, 7)));
      step();
      drive(1'b1, vals[1], 1'b0, 3'($urandom_range(0, 7)));
      step();
      drive(1'b1, vals[2], 1'b0, 3'($urandom_range(0, 7)));
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_full_ready: got in_ready=%b want 0", in_ready);
      end
      repeat (2) step();
      n_cmp++;
      if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, vals[0]}) begin
         n_bad++;
         $display("FAIL bp_hold: got ready=%b valid=%b res=%h want 0 1 %h", in_ready, out_valid, out_result, vals[0]);
      end
      out_ready = 1'b1;
      sent_c = 1'b0;
      for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
         logic took_in;
         if (out_valid && out_ready) got.push_back(out_result);
         took_in = in_valid && in_ready;
         step();
         if (took_in) begin
            sent_c = 1'b1;
            in_valid = 1'b0;
         end
      end
      n_cmp++;
      if (!sent_c || got.size() != 3) begin
         n_bad++;
         $display("FAIL bp_timeout: got %0d outputs, C accepted=%b want 3, 1", got.size(), sent_c);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got[i] !== vals[i]) begin
               n_bad++;
               $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], vals[i]);
            end
         end
      end
      drain();
   endtask

   task automatic test_streaming();
      logic [3:0] base;
      logic [3:0] d;
      base = m_count[3:0];
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d = 4'($urandom_range(0, 15));
         drive(1'b1, d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         step();
         n_cmp++;
         if ({in_ready, out_valid, out_result} !== {1'b1, 1'b1, d}) begin
            n_bad++;
            $display("FAIL stream[%0d]: got ready=%b valid=%b res=%h want 1 1 %h", i, in_ready, out_valid, out_result, d);
         end
      end
      drive(1'b0, 4'd0, 1'b0, 3'd0);
      step();
      n_cmp++;
      if (result_count[3:0] !== base + 4'd20 - 4'd0) begin
         n_bad++;
         $display("FAIL stream_count: got %0d want low nibble %0d", result_count, base + 4'd4);
      end
   endtask

   task automatic test_sticky_clear();
      out_ready = 1'b1;
      clear_sticky = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 3'd0);
      step();
      n_cmp++;
      if (sticky_c !== 1'b0) begin
         n_bad++;
         $display("FAIL sticky_clear: got %b want 0", sticky_c);
      end
      drive(1'b1, 4'h3, 1'b1, ALU_SEL_SUB);
      step();
      n_cmp++;
      if (sticky_c !== 1'b1) begin
         n_bad++;
         $display("FAIL sticky_set_wins: got %b want 1", sticky_c);
      end
      drive(1'b0, 4'd0, 1'b0, 3'd0);
      step();
      clear_sticky = 1'b0;
      drive(1'b1, 4'h9, 1'b1, ALU_SEL_OR);
      step();
      n_cmp++;
      if (sticky_c !== 1'b0) begin
         n_bad++;
         $display("FAIL sticky_unqualified: got %b want 0", sticky_c);
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      drive(1'b1, 4'hA, 1'b1, ALU_SEL_ADD);
      step();
      drive(1'b1, 4'h5, 1'b0, ALU_SEL_XOR);
      step();
      drive(1'b0, 4'd0, 1'b0, 3'd0);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, out_result, out_sel, out_c, out_z, out_n, sticky_c, result_count, w2_result_count}
          !== {1'b0, 1'b1, 4'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0}) begin
         n_bad++;
         $display("FAIL reset_async: got v%b r%b res=%h sel=%h c%b z%b n%b st%b cnt=%0d",
                  out_valid, in_ready, out_result, out_sel, out_c, out_z, out_n, sticky_c, result_count);
      end
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL reset_no_stale: got valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, 3'($urandom_range(0, 7)));
         step();
      end
      drive(1'b0, 4'd0, 1'b0, 3'd0);
      step();
      n_cmp++;
      if ({result_count, w2_result_count} !== {8'd5, 2'd1}) begin
         n_bad++;
         $display("FAIL count_wrap: got %0d/%0d want 5/1", result_count, w2_result_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)));
         out_ready    = 1'($urandom_range(0, 99) < 55);
         clear_sticky = 1'($urandom_range(0, 99) < 10);
         step();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_and_flags();
      test_backpressure();
      drain();
      test_streaming();
      test_sticky_clear();
      test_reset_midflight();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
